// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode definitions: opcodes, the NOP word and fetch FSM state encodings.
// Also imported by control so both stages agree on opcode values.
package fetch_stage_pkg;

    localparam logic [4:0]  OP_HALT  = 5'b00000;
    localparam logic [4:0]  OP_NOP   = 5'b00001;
    localparam logic [15:0] NOP_WORD = {OP_NOP, 11'd0};

    typedef enum logic [1:0] {
        ST_REQ    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HOLD   = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_e;

    function automatic logic is_halt(input logic [15:0] instr);
        return instr[15:11] == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter: synchronous reset to RESET_PC, load enable, next value is pc+2 or redirect target.
module pc_reg #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        sel_redirect_i,
    input  logic [15:0] redirect_pc_i,
    output logic [15:0] pc_o,
    output logic [15:0] pc_plus2_o
);

    logic [15:0] pc_q;
    logic [15:0] pc_d;

    assign pc_plus2_o = pc_q + 16'd2;
    assign pc_o       = pc_q;

    always_comb begin
        pc_d = sel_redirect_i ? redirect_pc_i : pc_plus2_o;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else if (load_i) begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, variable-latency imem handshake, one-word skid buffer, redirect squash, HALT.
// Optional ALIGN_CHECK_EN: odd fetch address halts the stage with err set instead of issuing a request.
//
// state     | meaning
// ST_REQ    | request asserted at pc; fills output slot or skid buffer on imem_done
// ST_DRAIN  | squashed access still outstanding; data discarded on imem_done
// ST_HOLD   | skid buffer full, no request until decode consumes
// ST_HALTED | HALT consumed (or misaligned fetch); no requests until reset
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = NOP_WORD
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [15:0] redirect_pc_i,
    output logic        imem_rd_o,
    output logic [15:0] imem_addr_o,
    input  logic [15:0] imem_rdata_i,
    input  logic        imem_done_i,
    output logic        if_valid_o,
    output logic [15:0] if_instr_o,
    output logic [15:0] if_pc_plus2_o,
    output logic        halted_o,
    output logic        err_o
);

    fetch_state_e state_q, state_d;
    logic        if_valid_q, if_valid_d;
    logic [15:0] if_instr_q, if_instr_d;
    logic [15:0] if_pc2_q, if_pc2_d;
    logic [15:0] buf_instr_q, buf_instr_d;
    logic [15:0] buf_pc2_q, buf_pc2_d;
    logic [15:0] drain_addr_q, drain_addr_d;
    logic        halted_q, halted_d;
    logic        err_q, err_d;

    logic        pc_load, pc_sel_redirect;
    logic [15:0] pc, pc_plus2;
    logic        consume, slot_free, halt_take, redirect_go, misalign, in_flight;

    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .load_i         (pc_load),
        .sel_redirect_i (pc_sel_redirect),
        .redirect_pc_i  (redirect_pc_i),
        .pc_o           (pc),
        .pc_plus2_o     (pc_plus2)
    );

`ifdef ALIGN_CHECK_EN
    assign misalign = (state_q == ST_REQ) && pc[0];
`else
    assign misalign = 1'b0;
`endif

    assign consume     = if_valid_q && !stall_i;
    assign slot_free   = !if_valid_q || consume;
    assign halt_take   = consume && is_halt(if_instr_q);
    // a pending halt (DRAIN with halted_q set) also ignores redirects
    assign redirect_go = redirect_valid_i && !halted_q && (state_q != ST_HALTED);
    assign in_flight   = ((state_q == ST_REQ) && !misalign) || (state_q == ST_DRAIN);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_REQ;
            if_valid_q   <= 1'b0;
            if_instr_q   <= NOP_INSTR;
            if_pc2_q     <= 16'h0000;
            buf_instr_q  <= 16'h0000;
            buf_pc2_q    <= 16'h0000;
            drain_addr_q <= 16'h0000;
            halted_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            if_valid_q   <= if_valid_d;
            if_instr_q   <= if_instr_d;
            if_pc2_q     <= if_pc2_d;
            buf_instr_q  <= buf_instr_d;
            buf_pc2_q    <= buf_pc2_d;
            drain_addr_q <= drain_addr_d;
            halted_q     <= halted_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        if_valid_d      = if_valid_q;
        if_instr_d      = if_instr_q;
        if_pc2_d        = if_pc2_q;
        buf_instr_d     = buf_instr_q;
        buf_pc2_d       = buf_pc2_q;
        drain_addr_d    = drain_addr_q;
        halted_d        = halted_q;
        err_d           = err_q;
        pc_load         = 1'b0;
        pc_sel_redirect = 1'b0;

        if (consume) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
        end

        unique case (state_q)
            ST_REQ: begin
                if (misalign) begin
                    err_d    = 1'b1;
                    halted_d = 1'b1;
                    state_d  = ST_HALTED;
                end else if (imem_done_i) begin
                    pc_load = 1'b1;
                    if (slot_free) begin
                        if_valid_d = 1'b1;
                        if_instr_d = imem_rdata_i;
                        if_pc2_d   = pc_plus2;
                    end else begin
                        buf_instr_d = imem_rdata_i;
                        buf_pc2_d   = pc_plus2;
                        state_d     = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (consume) begin
                    if_valid_d = 1'b1;
                    if_instr_d = buf_instr_q;
                    if_pc2_d   = buf_pc2_q;
                    state_d    = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (imem_done_i) begin
                    state_d = halted_q ? ST_HALTED : ST_REQ;
                end
            end
            default: ;
        endcase

        // an outstanding access must still complete before we park in HALTED
        if (halt_take && (state_q != ST_HALTED)) begin
            halted_d   = 1'b1;
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
            state_d    = (in_flight && !imem_done_i) ? ST_DRAIN : ST_HALTED;
            if (state_q == ST_REQ) begin
                drain_addr_d = pc;
            end
        end

        if (redirect_go) begin
            pc_load         = 1'b1;
            pc_sel_redirect = 1'b1;
            if_valid_d      = 1'b0;
            if_instr_d      = NOP_INSTR;
            halted_d        = halted_q;
            err_d           = err_q;
            if (in_flight && !imem_done_i) begin
                state_d = ST_DRAIN;
                if (state_q == ST_REQ) begin
                    drain_addr_d = pc;
                end
            end else begin
                state_d = ST_REQ;
            end
        end
    end

    always_comb begin
        imem_rd_o   = !rst_i && in_flight;
        imem_addr_o = (state_q == ST_DRAIN) ? drain_addr_q : pc;
    end

    assign if_valid_o    = if_valid_q;
    assign if_instr_o    = if_instr_q;
    assign if_pc_plus2_o = if_pc2_q;
    assign halted_o      = halted_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized stall/redirect/latency traffic
// scored against an in-order program-stream model of the delivered words.
module tb_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        redirect_valid_i;
    logic [15:0] redirect_pc_i;
    logic        imem_rd_o;
    logic [15:0] imem_addr_o;
    logic [15:0] imem_rdata_i;
    logic        imem_done_i;
    logic        if_valid_o;
    logic [15:0] if_instr_o;
    logic [15:0] if_pc_plus2_o;
    logic        halted_o;
    logic        err_o;

    fetch_stage dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_rd_o        (imem_rd_o),
        .imem_addr_o      (imem_addr_o),
        .imem_rdata_i     (imem_rdata_i),
        .imem_done_i      (imem_done_i),
        .if_valid_o       (if_valid_o),
        .if_instr_o       (if_instr_o),
        .if_pc_plus2_o    (if_pc_plus2_o),
        .halted_o         (halted_o),
        .err_o            (err_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks;
    int          n_errors;
    int          n_consumed;
    logic [15:0] halt_addr;
    int          mem_cnt;
    int          mem_lat;
    bit          rand_lat;
    logic        prev_rd, prev_done;
    logic [15:0] prev_addr;
    logic [15:0] exp_addr;
    bit          m_halted;
    int          halt_age;

    // Program image: never HALT/NOP opcodes except the chosen halt address.
    function automatic logic [15:0] memw(input logic [15:0] a);
        logic [4:0] op;
        if (a == halt_addr) return 16'h0000;
        op = 5'd2 + 5'(a[5:1] % 5'd30);
        return {op, a[11:1] ^ 11'h5A5 ^ {a[15:12], 7'd0}};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: answer memory, score any consume, advance, then check post-edge rules.
    task automatic tick();
        bit          redir_now, hold_prev, halt_now;
        logic [15:0] hold_instr, hold_pc2, w;
        if (imem_rd_o) begin
            if (prev_rd && !prev_done) chk("addr_stable", imem_addr_o, prev_addr);
            if (mem_cnt >= mem_lat) begin
                imem_done_i  = 1'b1;
                imem_rdata_i = memw(imem_addr_o);
                mem_cnt      = 0;
                if (rand_lat) mem_lat = $urandom_range(0, 3);
            end else begin
                imem_done_i  = 1'b0;
                imem_rdata_i = 16'($urandom);
                mem_cnt++;
            end
        end else begin
            imem_done_i = 1'b0;
            mem_cnt     = 0;
        end
        prev_rd   = imem_rd_o;
        prev_done = imem_done_i;
        prev_addr = imem_addr_o;

        redir_now  = redirect_valid_i && !m_halted;
        hold_prev  = if_valid_o && stall_i && !redir_now;
        hold_instr = if_instr_o;
        hold_pc2   = if_pc_plus2_o;
        halt_now   = 1'b0;
        if (if_valid_o && !stall_i && !redir_now) begin
            w = memw(exp_addr);
            chk("stream_instr", if_instr_o, w);
            chk("stream_pc2", if_pc_plus2_o, exp_addr + 16'd2);
            n_consumed++;
            if (w[15:11] == 5'b00000) halt_now = 1'b1;
            exp_addr = exp_addr + 16'd2;
        end
        if (redir_now) exp_addr = redirect_pc_i;

        @(posedge clk_i);
        #1;
        if (halt_now) m_halted = 1'b1;
        if (m_halted) begin
            chk("halted_set", 16'(halted_o), 16'd1);
            chk("halted_novalid", 16'(if_valid_o), 16'd0);
            halt_age++;
            if (halt_age > 6) chk("halted_no_rd", 16'(imem_rd_o), 16'd0);
        end else if (redir_now) begin
            chk("redir_squash_valid", 16'(if_valid_o), 16'd0);
            chk("redir_squash_instr", if_instr_o, 16'h0800);
        end else if (hold_prev) begin
            chk("hold_valid", 16'(if_valid_o), 16'd1);
            chk("hold_instr", if_instr_o, hold_instr);
            chk("hold_pc2", if_pc_plus2_o, hold_pc2);
        end
    endtask

    task automatic do_reset();
        rst_i            = 1'b1;
        stall_i          = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = 16'h0000;
        imem_done_i      = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_rd", 16'(imem_rd_o), 16'd0);
        chk("rst_valid", 16'(if_valid_o), 16'd0);
        chk("rst_instr", if_instr_o, 16'h0800);
        chk("rst_pc2", if_pc_plus2_o, 16'h0000);
        chk("rst_halted", 16'(halted_o), 16'd0);
        chk("rst_err", 16'(err_o), 16'd0);
        rst_i     = 1'b0;
        exp_addr  = 16'h0000;
        m_halted  = 1'b0;
        halt_age  = 0;
        mem_cnt   = 0;
        prev_rd   = 1'b0;
        prev_done = 1'b0;
        #1;
    endtask

    task automatic wait_valid(input int bound, input string tag);
        int k;
        k = 0;
        while (!if_valid_o && k < bound) begin
            tick();
            k++;
        end
        chk(tag, 16'(if_valid_o), 16'd1);
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        n_consumed   = 0;
        halt_addr    = 16'h0001;
        mem_lat      = 0;
        rand_lat     = 1'b0;
        imem_rdata_i = 16'h0000;

        // zero-latency memory streams one word per cycle
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("t1_valid", 16'(if_valid_o), 16'd1);
            chk("t1_pc2", if_pc_plus2_o, 16'(2 * k));
        end

        // slow memory with decode stall: second word parks in the buffer
        do_reset();
        mem_lat = 3;
        wait_valid(20, "t2_first");
        stall_i = 1'b1;
        repeat (6) tick();
        chk("t2_hold_no_rd", 16'(imem_rd_o), 16'd0);
        chk("t2_hold_pc2", if_pc_plus2_o, 16'h0002);
        stall_i = 1'b0;
        tick();
        chk("t2_buf_valid", 16'(if_valid_o), 16'd1);
        chk("t2_buf_order", if_pc_plus2_o, 16'h0004);

        // redirect while an access is pending: drain the old address, refetch at target
        tick();
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 16'h0040;
        tick();
        redirect_valid_i = 1'b0;
        chk("t3_drain_rd", 16'(imem_rd_o), 16'd1);
        chk("t3_drain_addr", imem_addr_o, 16'h0004);
        wait_valid(30, "t3_refetch");
        chk("t3_target_pc2", if_pc_plus2_o, 16'h0042);

        // fetch at FFFE wraps
        do_reset();
        mem_lat          = 0;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 16'hFFFE;
        tick();
        redirect_valid_i = 1'b0;
        wait_valid(10, "t5_valid");
        chk("t5_pc2_wrap", if_pc_plus2_o, 16'h0000);
        chk("t5_next_addr", imem_addr_o, 16'h0000);
        repeat (3) tick();

        // randomized stall / redirect / latency traffic
        do_reset();
        rand_lat   = 1'b1;
        mem_lat    = $urandom_range(0, 3);
        n_consumed = 0;
        for (int c = 0; c < 600; c++) begin
            stall_i          = ($urandom_range(0, 9) < 3);
            redirect_valid_i = ($urandom_range(0, 19) == 0);
            redirect_pc_i    = 16'($urandom_range(0, 32767)) << 1;
            tick();
        end
        stall_i          = 1'b0;
        redirect_valid_i = 1'b0;
        chk("rand_progress", 16'(n_consumed > 100), 16'd1);

        // HALT at 0008: sticky, no requests, redirects ignored
        do_reset();
        rand_lat  = 1'b0;
        mem_lat   = 0;
        halt_addr = 16'h0008;
        for (int k = 0; k < 30 && !halted_o; k++) tick();
        chk("t4_halted", 16'(halted_o), 16'd1);
        chk("t4_halted_pc_seen", exp_addr, 16'h000A);
        for (int k = 0; k < 20; k++) begin
            redirect_valid_i = k[0];
            redirect_pc_i    = 16'h0040;
            tick();
            chk("t4_no_rd", 16'(imem_rd_o), 16'd0);
        end
        redirect_valid_i = 1'b0;
        halt_addr        = 16'h0001;

        // odd redirect target
        do_reset();
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 16'h0041;
        tick();
        redirect_valid_i = 1'b0;
`ifdef ALIGN_CHECK_EN
        tick();
        tick();
        chk("t6_err", 16'(err_o), 16'd1);
        chk("t6_halted", 16'(halted_o), 16'd1);
        chk("t6_no_rd", 16'(imem_rd_o), 16'd0);
`else
        chk("t6_odd_addr", imem_addr_o, 16'h0041);
        chk("t6_odd_rd", 16'(imem_rd_o), 16'd1);
        chk("t6_err_zero", 16'(err_o), 16'd0);
        tick();
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
